// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU/funct codes and the stage state type for alu_decode_stage.
package alu_decode_stage_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA = 4'd9;

  localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
  localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
  localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
  localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/Funct to ALU_OP_* mapping; anything unmapped falls back to ADD.
module alu_decoder
  import alu_decode_stage_pkg::*;
(
  input  logic [1:0]          alu_op,
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_OP_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_OP_ADD;
      ALUOP_SUB: alu_ctrl = ALU_OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_AND: alu_ctrl = ALU_OP_AND;
          FUNCT_OR:  alu_ctrl = ALU_OP_OR;
          FUNCT_XOR: alu_ctrl = ALU_OP_XOR;
          FUNCT_NOR: alu_ctrl = ALU_OP_NOR;
          FUNCT_SLL: alu_ctrl = ALU_OP_SLL;
          FUNCT_SRL: alu_ctrl = ALU_OP_SRL;
          FUNCT_SRA: alu_ctrl = ALU_OP_SRA;
          FUNCT_SLT: alu_ctrl = ALU_OP_SLT;
          FUNCT_ADD: alu_ctrl = ALU_OP_ADD;
          FUNCT_SUB: alu_ctrl = ALU_OP_SUB;
          default:   alu_ctrl = ALU_OP_ADD;
        endcase
      end
      default: alu_ctrl = ALU_OP_ADD;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered, valid/ready ALU decode stage that also launches and waits out mul/div ops.
// state | meaning: IDLE nothing held | HOLD entry presented to execute | BUSY mul/div latency running
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              is_muldiv,
  output logic              illegal,
  output logic              muldiv_start,
  output logic [1:0]        muldiv_op,
  output logic              muldiv_busy
);

  localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT)) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t state, state_next;

  logic [ALU_OP_W-1:0] dec_ctrl;
  logic                dec_md;
  logic                dec_ill;
  logic [1:0]          dec_op;
  logic [CTRL_W-1:0]   ctrl_next;
  logic                accept;

  logic [CTRL_W-1:0] ctrl_q;
  logic              md_q;
  logic              ill_q;
  logic [1:0]        md_op_q;
  logic              start_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt;

  alu_decoder u_alu_decoder (
    .alu_op   (ALUOp),
    .funct    (Funct),
    .alu_ctrl (dec_ctrl)
  );

  always_comb begin
    dec_md  = 1'b0;
    dec_ill = 1'b0;
    dec_op  = MULDIV_OP_MULT;
    case (ALUOp)
      ALUOP_FUNCT: begin
        case (Funct)
          FUNCT_MULT:  begin dec_md = 1'b1; dec_op = MULDIV_OP_MULT;  end
          FUNCT_MULTU: begin dec_md = 1'b1; dec_op = MULDIV_OP_MULTU; end
          FUNCT_DIV:   begin dec_md = 1'b1; dec_op = MULDIV_OP_DIV;   end
          FUNCT_DIVU:  begin dec_md = 1'b1; dec_op = MULDIV_OP_DIVU;  end
          FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR, FUNCT_SLL,
          FUNCT_SRL, FUNCT_SRA, FUNCT_SLT, FUNCT_ADD, FUNCT_SUB: dec_ill = 1'b0;
          default: dec_ill = 1'b1;
        endcase
      end
      ALUOP_RSVD: dec_ill = 1'b1;
      default:    dec_ill = 1'b0;
    endcase
  end

  assign ctrl_next = (dec_md || dec_ill) ? CTRL_W'(ALU_OP_ADD) : CTRL_W'(dec_ctrl);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;

  // BUSY outlives busy_q by one cycle: the result slot opens the cycle after the counter ends.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          state_next = dec_md ? ST_BUSY : ST_HOLD;
        end else if ((state == ST_HOLD) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!busy_q) state_next = ST_HOLD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      ctrl_q  <= '0;
      md_q    <= 1'b0;
      ill_q   <= 1'b0;
      md_op_q <= 2'b00;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      start_q <= accept && dec_md;
      if (accept) begin
        ctrl_q <= ctrl_next;
        md_q   <= dec_md;
        ill_q  <= dec_ill;
        if (dec_md) begin
          md_op_q <= dec_op;
          busy_q  <= 1'b1;
          cnt     <= dec_op[1] ? DIV_CNT : MUL_CNT;
        end
      end else if ((state == ST_BUSY) && busy_q) begin
        if (cnt == '0) begin
          busy_q <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign out_valid    = (state == ST_HOLD);
  assign ALUControl   = ctrl_q;
  assign is_muldiv    = md_q;
  assign illegal      = ill_q;
  assign muldiv_start = start_q;
  assign muldiv_op    = md_op_q;
  assign muldiv_busy  = busy_q;

endmodule
